canvas_wr_sched: RTL and testbench

Write-port scheduler for the 32768 x 9-bit canvas memory in the VGA RAM. Shares the single canvas write port (`c_addr`/`c_data`) between `N_REQ` requesters (camera pixel writer, finger overlay painter, UI painter) using round-robin valid/ready arbitration. Also contains a clear engine that sweeps the whole canvas to a fixed colour on command. Sits between the drawing engines and the VGA RAM; the VGA scan-out read path is untouched.

---
 rtl/canvas_wr_sched.sv | 137 +++++++++++++
 tb/tb_canvas_wr_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_wr_sched.sv
// Round-robin scheduler for the canvas write port, with an optional full-canvas clear engine (CANVAS_CLEAR_EN).
// Grants are combinational and the write is registered one cycle later; requesters wait on req_ready, and none are granted while a sweep runs.
`timescale 1ns/1ps
module canvas_wr_sched #(
  parameter int                N_REQ     = 3,
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 9,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic [ADDR_W-1:0]       c_addr,
  output logic [DATA_W-1:0]       c_data,
  output logic                    c_we
);
  localparam int               PTR_W    = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W-1:0] idx;
  logic [N_REQ-1:0] grant;
  logic             found;
  int               k;
  wr_t              sel;
  wr_t              wr_q;
  logic             arb_en;
  logic             xfer;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    idx     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      k = int'(ptr) + j;
      if (k >= N_REQ) k = k - N_REQ;
      idx = PTR_W'(k);
      if (!found && req_valid[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.addr = req_addr[i*ADDR_W +: ADDR_W];
        sel.data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign nxt_ptr   = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
  assign req_ready = arb_en ? grant : '0;
  assign xfer      = |req_ready;
  assign c_addr    = wr_q.addr;
  assign c_data    = wr_q.data;

`ifdef CANVAS_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic            busy;

  // A start pulse in IDLE beats any same-cycle request.
  assign arb_en     = rst && (state == IDLE) && !clear_start;
  assign clear_busy = busy;
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign arb_en             = rst;
  assign clear_busy         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr  <= '0;
      wr_q <= '0;
      c_we <= 1'b0;
`ifdef CANVAS_CLEAR_EN
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
`endif
    end else begin
`ifdef CANVAS_CLEAR_EN
      if (state == CLEAR) begin
        // cnt tracks the address currently on c_addr; stop after the top word.
        if (cnt == LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          c_we  <= 1'b0;
        end else begin
          cnt       <= cnt + 1'b1;
          wr_q.addr <= ADDR_W'(cnt + 1'b1);
          c_we      <= 1'b1;
        end
      end else if (clear_start) begin
        state <= CLEAR;
        busy  <= 1'b1;
        cnt   <= '0;
        wr_q  <= '{addr: '0, data: CLEAR_VAL};
        c_we  <= 1'b1;
      end else
`endif
      if (xfer) begin
        ptr  <= nxt_ptr;
        wr_q <= sel;
        c_we <= 1'b1;
      end else begin
        c_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_canvas_wr_sched.sv
// Bench for canvas_wr_sched: directed reset/round-robin/single/clear steps plus random traffic,
// each cycle compared against a cycle-level reference model of grant order and the registered write port.
`timescale 1ns/1ps
module tb_canvas_wr_sched;
  localparam int             N  = 3;
  localparam int             AW = 15;
  localparam int             DW = 9;
  localparam logic [DW-1:0]  CV = 9'h000;
`ifdef CANVAS_CLEAR_EN
  localparam bit CLR_ON = 1'b1;
`else
  localparam bit CLR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cs;
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          clear_busy;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic          c_we;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr[gi*AW +: AW] = a[gi];
    assign req_data[gi*DW +: DW] = d[gi];
  end

  canvas_wr_sched #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(CV)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .clear_start(cs), .clear_busy(clear_busy),
    .c_addr(c_addr), .c_data(c_data), .c_we(c_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: expected write-port contents and rotating priority.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            cur_g;

  int busy_cnt, bad, k;
  bit done;
  logic [N-1:0] rr_seq [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    logic [1:0] ix;
    for (int j = 0; j < N; j++) begin
      ix = 2'((m_ptr + j) % N);
      if (v[ix]) return (m_ptr + j) % N;
    end
    return -1;
  endfunction

  task automatic newreq(input int i);
    a[2'(i)] = AW'($urandom);
    d[2'(i)] = DW'($urandom);
  endtask

  task automatic check_now();
    logic [N-1:0] er;
    chk("c_we", 32'(c_we), 32'(m_we));
    chk("c_addr", 32'(c_addr), 32'(m_addr));
    chk("c_data", 32'(c_data), 32'(m_data));
    chk("clear_busy", 32'(clear_busy), 32'(1'b0));
    if (!rst || (CLR_ON && cs)) cur_g = -1;
    else cur_g = pick();
    er = (cur_g < 0) ? '0 : N'(1 << cur_g);
    chk("req_ready", 32'(req_ready), 32'(er));
  endtask

  task automatic sample();
    #3;
    check_now();
  endtask

  task automatic advance();
    if (!rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (cur_g >= 0) begin
      m_we   = 1'b1;
      m_addr = a[2'(cur_g)];
      m_data = d[2'(cur_g)];
      m_ptr  = (cur_g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
    rst = 1'b0; cs = 1'b0; v = '1;
    for (int i = 0; i < N; i++) newreq(i);
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; cur_g = -1;
    @(posedge clk);
    #1;

    // Reset held with every requester valid.
    repeat (3) begin
      sample();
      advance();
    end

    // Release: all valid rotates 0,1,2,...; dropping req1 alternates 0,2.
    rst = 1'b1;
    for (int s = 0; s < 10; s++) begin
      if (s == 6) v = 3'b101;
      sample();
      chk("rr_grant", 32'(req_ready), 32'(rr_seq[s]));
      if (s > 0) chk("rr_write", 32'(c_we), 32'(1'b1));
      advance();
      if (cur_g >= 0) newreq(cur_g);
    end

    // Single requester, then idle cycle with held address/data.
    v = 3'b010; a[1] = 15'h1234; d[1] = 9'h1AB;
    sample();
    chk("single_rdy", 32'(req_ready), 32'(3'b010));
    advance();
    v = '0;
    sample();
    chk("single_we", 32'(c_we), 32'(1'b1));
    chk("single_addr", 32'(c_addr), 32'(15'h1234));
    chk("single_data", 32'(c_data), 32'(9'h1AB));
    advance();
    sample();
    chk("single_idle_we", 32'(c_we), 32'(1'b0));
    chk("single_hold_addr", 32'(c_addr), 32'(15'h1234));
    chk("single_hold_data", 32'(c_data), 32'(9'h1AB));
    advance();

    // Random traffic obeying hold-until-transfer.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[2'(i)]) begin
          if ($urandom_range(0, 1) == 1) begin
            v[2'(i)] = 1'b1;
            newreq(i);
          end
        end else if (cur_g == i) begin
          if ($urandom_range(0, 2) == 0) v[2'(i)] = 1'b0;
          else newreq(i);
        end
      end
      sample();
      advance();
    end
    v = '0;
    sample();
    advance();

`ifdef CANVAS_CLEAR_EN
    // Full sweep with req0 waiting and a restart pulse at address 100.
    v = 3'b001; newreq(0); cs = 1'b1;
    sample();
    chk("clr_start_rdy", 32'(req_ready), 32'(3'b000));
    @(posedge clk);
    #1;
    cs = 1'b0;
    busy_cnt = 0; bad = 0; k = 0; done = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      #3;
      if (clear_busy !== 1'b1) begin
        done = 1'b1;
        break;
      end
      if (c_we !== 1'b1 || c_addr !== AW'(k) || c_data !== CV || req_ready !== '0) bad++;
      busy_cnt++;
      k++;
      @(posedge clk);
      #1;
      cs = (k == 100);
    end
    if (!done) #3;
    cs = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'(32768));
    chk("clr_bad_writes", 32'(bad), 32'(0));
    m_we = 1'b0; m_addr = '1; m_data = CV;
    check_now();
    chk("clr_post_grant", 32'(req_ready), 32'(3'b001));
    advance();
    v = '0;
    sample();
    chk("clr_post_write", 32'(c_addr), 32'(a[0]));
    advance();

    // Reset in the middle of a sweep.
    cs = 1'b1;
    sample();
    @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (500) @(posedge clk);
    #4;
    chk("mid_addr", 32'(c_addr), 32'(500));
    chk("mid_busy", 32'(clear_busy), 32'(1'b1));
    rst = 1'b0;
    @(posedge clk);
    #4;
    chk("mid_rst_we", 32'(c_we), 32'(1'b0));
    chk("mid_rst_busy", 32'(clear_busy), 32'(1'b0));
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b1; v = 3'b100; newreq(2);
    sample();
    chk("mid_rel_grant", 32'(req_ready), 32'(3'b100));
    advance();
    v = '0;
    sample();
    chk("mid_rel_we", 32'(c_we), 32'(1'b1));
    chk("mid_rel_addr", 32'(c_addr), 32'(a[2]));
    advance();
`else
    // Without the clear engine a start pulse is ignored.
    v = 3'b001; newreq(0); cs = 1'b1;
    sample();
    chk("noclr_grant", 32'(req_ready), 32'(3'b001));
    chk("noclr_busy", 32'(clear_busy), 32'(1'b0));
    advance();
    cs = 1'b0; v = '0;
    sample();
    chk("noclr_write", 32'(c_addr), 32'(a[0]));
    advance();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
